// File: rtl/blockram_fill_evict_ctrl.sv
// Lookup/fill controller for a 1-cycle-latency dual-port block RAM with an evict FIFO.
// Optional macro EVICT_SKIP_INVALID_EN: per-set valid bits suppress evicts of never-filled sets.
module blockram_fill_evict_ctrl #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SET                  = 64,
    parameter int SET_PTR_WIDTH_IN_BITS       = 6,
    parameter int EVICT_QUEUE_DEPTH           = 4
) (
    input  logic                                   clk_in,
    input  logic                                   reset_in,
    input  logic                                   lookup_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       lookup_set_addr_in,
    output logic                                   lookup_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] lookup_element_out,
    input  logic                                   fill_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       fill_set_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] fill_element_in,
    output logic                                   fill_ready_out,
    output logic                                   evict_valid_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       evict_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] evict_element_out,
    input  logic                                   evict_ready_in,
    output logic                                   ram_read_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_read_set_addr_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in,
    output logic                                   ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_write_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_evict_element_in
);
    localparam int PTR_W = (EVICT_QUEUE_DEPTH > 1) ? $clog2(EVICT_QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    if (NUMBER_SET > (1 << SET_PTR_WIDTH_IN_BITS)) begin : g_bad_set_cfg
        $error("NUMBER_SET does not fit in SET_PTR_WIDTH_IN_BITS");
    end
    if ((EVICT_QUEUE_DEPTH < 2) || ((EVICT_QUEUE_DEPTH & (EVICT_QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth_cfg
        $error("EVICT_QUEUE_DEPTH must be a power of two and at least 2");
    end

    logic                                   lookup_valid_q;
    logic                                   pending_q;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       fill_addr_q;
    logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                       count_q, count_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       addr_mem_q [EVICT_QUEUE_DEPTH];
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] data_mem_q [EVICT_QUEUE_DEPTH];

    logic           lookup_fire;
    logic           fill_fire;
    logic           push;
    logic           pop;
    logic [CNT_W:0] occupancy;

    // Stage T: acceptance and RAM command
    assign lookup_fire    = lookup_valid_in & ~reset_in;
    assign occupancy      = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
    assign fill_ready_out = ~reset_in & (occupancy < (CNT_W + 1)'(EVICT_QUEUE_DEPTH));
    assign fill_fire      = fill_valid_in & fill_ready_out;

    assign ram_read_en_out        = lookup_fire | fill_fire;
    assign ram_write_en_out       = fill_fire;
    assign ram_read_set_addr_out  = reset_in ? '0 :
                                    (lookup_fire ? lookup_set_addr_in : fill_set_addr_in);
    assign ram_write_set_addr_out = reset_in ? '0 : fill_set_addr_in;
    assign ram_write_element_out  = reset_in ? '0 : fill_element_in;

    // Stage T+1: lookup response and evict capture
    assign lookup_valid_out   = lookup_valid_q & ~reset_in;
    assign lookup_element_out = lookup_valid_out ? ram_read_element_in : '0;

`ifdef EVICT_SKIP_INVALID_EN
    logic [NUMBER_SET-1:0] set_valid_q;
    logic                  was_valid_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            set_valid_q <= '0;
            was_valid_q <= 1'b0;
        end else if (fill_fire) begin
            set_valid_q[fill_set_addr_in] <= 1'b1;
            was_valid_q                   <= set_valid_q[fill_set_addr_in];
        end
    end

    // A never-filled set holds garbage, so its eviction is dropped; pending still reserves the slot.
    assign push = pending_q & was_valid_q & ~reset_in;
`else
    assign push = pending_q & ~reset_in;
`endif

    // Evict FIFO
    assign evict_valid_out    = ~reset_in & (count_q != '0);
    assign pop                = evict_valid_out & evict_ready_in;
    assign evict_set_addr_out = evict_valid_out ? addr_mem_q[rd_ptr_q] : '0;
    assign evict_element_out  = evict_valid_out ? data_mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            lookup_valid_q <= 1'b0;
            pending_q      <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            lookup_valid_q <= lookup_fire;
            pending_q      <= fill_fire;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_fire) begin
            fill_addr_q <= fill_set_addr_in;
        end
        if (push) begin
            addr_mem_q[wr_ptr_q] <= fill_addr_q;
            data_mem_q[wr_ptr_q] <= ram_evict_element_in;
        end
    end
endmodule

// File: tb/tb_blockram_fill_evict_ctrl.sv
// Directed bench for blockram_fill_evict_ctrl with a behavioural read-before-write RAM.
// Build with EVICT_SKIP_INVALID_EN defined to exercise the valid-bit variant.
module tb_blockram_fill_evict_ctrl;
    localparam int EW = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          lookup_valid_in;
    logic [AW-1:0] lookup_set_addr_in;
    logic          lookup_valid_out;
    logic [EW-1:0] lookup_element_out;
    logic          fill_valid_in;
    logic [AW-1:0] fill_set_addr_in;
    logic [EW-1:0] fill_element_in;
    logic          fill_ready_out;
    logic          evict_valid_out;
    logic [AW-1:0] evict_set_addr_out;
    logic [EW-1:0] evict_element_out;
    logic          evict_ready_in;
    logic          ram_read_en;
    logic [AW-1:0] ram_read_addr;
    logic [EW-1:0] ram_read_data;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr;
    logic [EW-1:0] ram_write_data;
    logic [EW-1:0] ram_evict_data;

    logic [EW-1:0] ram_mem [64];

    int checks = 0;
    int errors = 0;

    blockram_fill_evict_ctrl dut (
        .clk_in                (clk),
        .reset_in              (reset_in),
        .lookup_valid_in       (lookup_valid_in),
        .lookup_set_addr_in    (lookup_set_addr_in),
        .lookup_valid_out      (lookup_valid_out),
        .lookup_element_out    (lookup_element_out),
        .fill_valid_in         (fill_valid_in),
        .fill_set_addr_in      (fill_set_addr_in),
        .fill_element_in       (fill_element_in),
        .fill_ready_out        (fill_ready_out),
        .evict_valid_out       (evict_valid_out),
        .evict_set_addr_out    (evict_set_addr_out),
        .evict_element_out     (evict_element_out),
        .evict_ready_in        (evict_ready_in),
        .ram_read_en_out       (ram_read_en),
        .ram_read_set_addr_out (ram_read_addr),
        .ram_read_element_in   (ram_read_data),
        .ram_write_en_out      (ram_write_en),
        .ram_write_set_addr_out(ram_write_addr),
        .ram_write_element_out (ram_write_data),
        .ram_evict_element_in  (ram_evict_data)
    );

    always #5 clk = ~clk;

    // Block RAM: 1-cycle read, old data on the write port, writes only with read enable.
    always @(posedge clk) begin
        if (ram_read_en) begin
            ram_read_data <= ram_mem[ram_read_addr];
            if (ram_write_en) begin
                ram_evict_data          <= ram_mem[ram_write_addr];
                ram_mem[ram_write_addr] <= ram_write_data;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        lookup_valid_in    = 1'b0;
        lookup_set_addr_in = '0;
        fill_valid_in      = 1'b0;
        fill_set_addr_in   = '0;
        fill_element_in    = '0;
        evict_ready_in     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [AW-1:0] exp_addr [4];
        logic [EW-1:0] exp_data [4];
        exp_addr = '{6'd17, 6'd18, 6'd19, 6'd24};
        exp_data = '{64'h101, 64'h102, 64'h103, 64'h0};

        for (int i = 0; i < 64; i++) ram_mem[i] = '0;
        ram_mem[5] = 64'hAA;
        ram_mem[3] = 64'h22;
        ram_mem[7] = 64'h5;
        ram_mem[4] = 64'h44;
        for (int i = 0; i < 8; i++) ram_mem[16+i] = 64'h100 + 64'(i);

        // Reset with active requests on the inputs
        reset_in           = 1'b1;
        lookup_valid_in    = 1'b1;
        lookup_set_addr_in = 6'd5;
        fill_valid_in      = 1'b1;
        fill_set_addr_in   = 6'd3;
        fill_element_in    = 64'h77;
        evict_ready_in     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_rd_en",     64'(ram_read_en), 64'd0);
        check("rst_wr_en",     64'(ram_write_en), 64'd0);
        check("rst_fill_rdy",  64'(fill_ready_out), 64'd0);
        check("rst_lk_vld",    64'(lookup_valid_out), 64'd0);
        check("rst_ev_vld",    64'(evict_valid_out), 64'd0);
        check("rst_wr_data",   ram_write_data, 64'd0);
        @(negedge clk);
        reset_in = 1'b0;
        idle_inputs();

        // Lookup of set 5
        @(negedge clk);
        lookup_valid_in = 1'b1; lookup_set_addr_in = 6'd5;
        #1;
        check("lk_rd_en",   64'(ram_read_en), 64'd1);
        check("lk_rd_addr", 64'(ram_read_addr), 64'd5);
        check("lk_wr_en",   64'(ram_write_en), 64'd0);
        @(negedge clk);
        lookup_valid_in = 1'b0;
        #1;
        check("lk_vld_t1",  64'(lookup_valid_out), 64'd1);
        check("lk_data_t1", lookup_element_out, 64'hAA);
        @(negedge clk);
        #1;
        check("lk_vld_t2",  64'(lookup_valid_out), 64'd0);

`ifndef EVICT_SKIP_INVALID_EN
        // Fill set 3 evicts the old 0x22
        @(negedge clk);
        fill_valid_in = 1'b1; fill_set_addr_in = 6'd3; fill_element_in = 64'h11;
        #1;
        check("fill_rdy",     64'(fill_ready_out), 64'd1);
        check("fill_wr_en",   64'(ram_write_en), 64'd1);
        check("fill_rd_addr", 64'(ram_read_addr), 64'd3);
        check("fill_wr_addr", 64'(ram_write_addr), 64'd3);
        check("fill_wr_data", ram_write_data, 64'h11);
        @(negedge clk);
        fill_valid_in = 1'b0;
        #1;
        check("ev_vld_t1", 64'(evict_valid_out), 64'd0);
        @(negedge clk);
        #1;
        check("ev_vld_t2",  64'(evict_valid_out), 64'd1);
        check("ev_addr_t2", 64'(evict_set_addr_out), 64'd3);
        check("ev_data_t2", evict_element_out, 64'h22);
        evict_ready_in = 1'b1;
        @(negedge clk);
        evict_ready_in = 1'b0;
        #1;
        check("ev_empty", 64'(evict_valid_out), 64'd0);
        lookup_valid_in = 1'b1; lookup_set_addr_in = 6'd3;
        @(negedge clk);
        lookup_valid_in = 1'b0;
        #1;
        check("lk_after_fill", lookup_element_out, 64'h11);
`else
        // Set 2 never filled: first fill evicts nothing, second evicts the first fill's data
        @(negedge clk);
        fill_valid_in = 1'b1; fill_set_addr_in = 6'd2; fill_element_in = 64'hA1;
        @(negedge clk);
        fill_valid_in = 1'b0;
        @(negedge clk);
        #1;
        check("inv_ev_vld_t2", 64'(evict_valid_out), 64'd0);
        @(negedge clk);
        #1;
        check("inv_ev_vld_t3", 64'(evict_valid_out), 64'd0);
        fill_valid_in = 1'b1; fill_set_addr_in = 6'd2; fill_element_in = 64'hB2;
        @(negedge clk);
        fill_valid_in = 1'b0;
        @(negedge clk);
        #1;
        check("val_ev_vld",  64'(evict_valid_out), 64'd1);
        check("val_ev_addr", 64'(evict_set_addr_out), 64'd2);
        check("val_ev_data", evict_element_out, 64'hA1);
        evict_ready_in = 1'b1;
        @(negedge clk);
        evict_ready_in = 1'b0;
        #1;
        check("val_ev_empty", 64'(evict_valid_out), 64'd0);
`endif

        // Same-cycle lookup and fill of set 7
        @(negedge clk);
        lookup_valid_in = 1'b1; lookup_set_addr_in = 6'd7;
        fill_valid_in   = 1'b1; fill_set_addr_in   = 6'd7; fill_element_in = 64'h9;
        #1;
        check("same_rd_addr", 64'(ram_read_addr), 64'd7);
        check("same_wr_en",   64'(ram_write_en), 64'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("same_lk_vld",  64'(lookup_valid_out), 64'd1);
        check("same_lk_data", lookup_element_out, 64'h5);
        @(negedge clk);
        #1;
`ifndef EVICT_SKIP_INVALID_EN
        check("same_ev_vld",  64'(evict_valid_out), 64'd1);
        check("same_ev_addr", 64'(evict_set_addr_out), 64'd7);
        check("same_ev_data", evict_element_out, 64'h5);
        evict_ready_in = 1'b1;
        @(negedge clk);
        evict_ready_in = 1'b0;
`else
        check("same_ev_none", 64'(evict_valid_out), 64'd0);
`endif

`ifndef EVICT_SKIP_INVALID_EN
        // Back-to-back fills into a stalled evict queue
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            fill_valid_in = 1'b1; fill_set_addr_in = AW'(16 + c); fill_element_in = 64'h200 + 64'(c);
            #1;
            if (fill_ready_out) acc++;
        end
        check("full_accepted", 64'(acc), 64'd4);
        check("full_ready",    64'(fill_ready_out), 64'd0);
        @(negedge clk);
        fill_set_addr_in = 6'd30;
        evict_ready_in   = 1'b1;
        #1;
        check("head_addr",      64'(evict_set_addr_out), 64'd16);
        check("head_data",      evict_element_out, 64'h100);
        check("pop_cycle_rdy",  64'(fill_ready_out), 64'd0);
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            evict_ready_in = 1'b0; fill_set_addr_in = AW'(24 + c); fill_element_in = 64'h300 + 64'(c);
            #1;
            if (fill_ready_out) acc++;
        end
        check("after_pop_accepted", 64'(acc), 64'd1);
        fill_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            evict_ready_in = 1'b1;
            #1;
            check("drain_vld",  64'(evict_valid_out), 64'd1);
            check("drain_addr", 64'(evict_set_addr_out), 64'(exp_addr[k]));
            check("drain_data", evict_element_out, exp_data[k]);
        end
        @(negedge clk);
        evict_ready_in = 1'b0;
        #1;
        check("drain_empty", 64'(evict_valid_out), 64'd0);
`endif

        // Reset right after a fill drops the in-flight eviction
        @(negedge clk);
        fill_valid_in = 1'b1; fill_set_addr_in = 6'd4; fill_element_in = 64'h45;
        #1;
        check("rf_fill_rdy", 64'(fill_ready_out), 64'd1);
        @(negedge clk);
        fill_valid_in = 1'b0;
        reset_in      = 1'b1;
        #1;
        check("rf_ev_vld_rst", 64'(evict_valid_out), 64'd0);
        check("rf_rdy_rst",    64'(fill_ready_out), 64'd0);
        @(negedge clk);
        reset_in = 1'b0;
        #1;
        check("rf_ev_vld_a1", 64'(evict_valid_out), 64'd0);
        check("rf_rdy_a1",    64'(fill_ready_out), 64'd1);
        @(negedge clk);
        #1;
        check("rf_ev_vld_a2", 64'(evict_valid_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/blockram_fill_evict_ctrl.md
BLOCKRAM_FILL_EVICT_CTRL -- requirements
Module: blockram_fill_evict_ctrl

Interface
REQ-001 SHALL have parameters: SINGLE_ELEMENT_SIZE_IN_BITS, 64, element width; NUMBER_SET, 64, sets in the attached RAM; SET_PTR_WIDTH_IN_BITS, 6, set address width; EVICT_QUEUE_DEPTH, 4, evict FIFO entries (power of two, at least 2).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_in, in, 1, single clock.
- reset_in, in, 1, synchronous active-high reset.
- lookup_valid_in, in, 1, read request; lookup_set_addr_in, in, SET_PTR_WIDTH, read set address.
- lookup_valid_out, out, 1, read response valid; lookup_element_out, out, ELEM, read response data.
- fill_valid_in, in, 1, fill request; fill_set_addr_in, in, SET_PTR_WIDTH, fill set address; fill_element_in, in, ELEM, fill data; fill_ready_out, out, 1, fill accepted this cycle when high with fill_valid_in.
- evict_valid_out, out, 1, evict queue head valid; evict_set_addr_out, out, SET_PTR_WIDTH, evicted set; evict_element_out, out, ELEM, evicted data; evict_ready_in, in, 1, consumer pops the head.
- ram_read_en_out, out, 1; ram_read_set_addr_out, out, SET_PTR_WIDTH; ram_read_element_in, in, ELEM.
- ram_write_en_out, out, 1; ram_write_set_addr_out, out, SET_PTR_WIDTH; ram_write_element_out, out, ELEM; ram_evict_element_in, in, ELEM.
- The ram_* ports connect to a dual-port block RAM that has 1-cycle read latency, read-before-write eviction, and performs writes only while its read enable is high.

Function
REQ-003 Lookups SHALL never stall; a lookup is accepted in every cycle in which lookup_valid_in=1 and reset_in=0.
REQ-004 fill_fire SHALL equal fill_valid_in & fill_ready_out; fill_ready_out SHALL equal !reset_in & (queue_count + pending) < EVICT_QUEUE_DEPTH, where pending=1 if a fill fired in the previous cycle.
REQ-005 In the acceptance cycle T, ram_read_en_out SHALL equal lookup fire | fill_fire, and ram_write_en_out SHALL equal fill_fire; both are combinational.
REQ-006 In cycle T, ram_read_set_addr_out SHALL equal lookup_set_addr_in when a lookup fires; otherwise it SHALL equal fill_set_addr_in.
REQ-007 In cycle T, ram_write_set_addr_out and ram_write_element_out SHALL equal fill_set_addr_in and fill_element_in.
REQ-008 For a lookup accepted at T, lookup_valid_out SHALL be high for exactly cycle T+1, and lookup_element_out SHALL equal ram_read_element_in during T+1; there is no backpressure on responses.
REQ-009 For a fill accepted at T, the controller SHALL register the fill address at T; at the end of T+1 it SHALL push {address, ram_evict_element_in} into the evict FIFO, so evict_valid_out can first rise at T+2.
REQ-010 The evict FIFO SHALL be first-in first-out; the head pops on evict_valid_out & evict_ready_in; a push and a pop in the same cycle SHALL leave queue_count unchanged.
REQ-011 The FIFO SHALL never overflow, which REQ-004 guarantees; evict_valid_out SHALL be 0 when the FIFO is empty, and evict_set_addr_out and evict_element_out are don't-care when it is empty.
REQ-012 A lookup and a fill to the same set in the same cycle SHALL return the old data on the lookup, and the evict entry SHALL carry the same old data.
REQ-013 Back-to-back fills SHALL sustain 1 per cycle while queue_count + pending < EVICT_QUEUE_DEPTH.

Reset
REQ-014 While reset_in=1, lookup_valid_out, evict_valid_out, fill_ready_out, ram_read_en_out and ram_write_en_out SHALL be 0.
REQ-015 Reset SHALL clear the FIFO pointers, queue_count and pending; a fill in flight when reset asserts SHALL produce no evict entry.
REQ-016 Reset SHALL clear all data outputs to 0; RAM contents are not cleared.

Configuration
REQ-017 Macro EVICT_SKIP_INVALID_EN: when defined, the controller SHALL keep NUMBER_SET per-set valid bits, cleared by reset and set by each fill_fire.
REQ-018 With the macro defined, a fill to a set whose valid bit is 0 at T SHALL push no evict entry, and pending SHALL still count for that fill for one cycle.
REQ-019 Without the macro, no valid bits SHALL exist and every fill SHALL push exactly one evict entry.

Verification
REQ-020 Lookup set 5 at T with the RAM holding 0xAA at set 5 -> lookup_valid_out=1 at T+1 only, lookup_element_out=0xAA.
REQ-021 Fill set 3 with 0x11 while the RAM holds 0x22 at set 3 (macro off) -> evict entry {3, 0x22} with evict_valid_out=1 at T+2; a later lookup of set 3 returns 0x11.
REQ-022 Depth 4, evict_ready_in=0, fills every cycle -> exactly 4 fills accepted, then fill_ready_out=0; one pop -> exactly one more fill accepted.
REQ-023 Same-cycle lookup and fill to set 7 (old 0x5, new 0x9) -> lookup returns 0x5, evict entry {7, 0x5}.
REQ-024 Macro on: reset, then fill set 2 twice -> only the second fill produces an evict entry, carrying the first fill's data.
REQ-025 Reset asserted at T+1 after a fill at T -> no evict entry, and queue_count=0 after reset.
